// File: rtl/sext_field_packer.sv
// Narrows a 16-bit two's-complement value to an LC-3 imm5/offset6/PCoffset9/PCoffset11
// field, flags misfits and buffers results in a 2-entry FIFO. Define SEXT_PACK_SAT_EN to saturate misfits.
module sext_field_packer #(
    parameter int DEPTH = 2,
    parameter int ERR_W = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [15:0]      IN_DATA,
    input  logic [1:0]       IN_SEL,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [10:0]      OUT_FIELD,
    output logic [1:0]       OUT_SEL,
    output logic             OUT_FIT,
    output logic [ERR_W-1:0] ERR_COUNT
);

    localparam int              ENTRY_W = 14;
    localparam logic [1:0]      FULL    = 2'(DEPTH);
    localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

    // The value fits W bits when every bit from 15 down to W-1 matches the new sign bit.
    function automatic logic field_fits(input logic [15:0] d, input logic [1:0] sel);
        logic ok;
        case (sel)
            2'd0:    ok = (d[15:4]  == {12{d[4]}});
            2'd1:    ok = (d[15:5]  == {11{d[5]}});
            2'd2:    ok = (d[15:8]  == {8{d[8]}});
            default: ok = (d[15:10] == {6{d[10]}});
        endcase
        return ok;
    endfunction

    function automatic logic [10:0] trunc_field(input logic [10:0] d, input logic [1:0] sel);
        logic [10:0] f;
        case (sel)
            2'd0:    f = {6'b0, d[4:0]};
            2'd1:    f = {5'b0, d[5:0]};
            2'd2:    f = {2'b0, d[8:0]};
            default: f = d[10:0];
        endcase
        return f;
    endfunction

`ifdef SEXT_PACK_SAT_EN
    function automatic logic [10:0] sat_field(input logic neg, input logic [1:0] sel);
        logic [10:0] f;
        case (sel)
            2'd0:    f = neg ? 11'h010 : 11'h00F;
            2'd1:    f = neg ? 11'h020 : 11'h01F;
            2'd2:    f = neg ? 11'h100 : 11'h0FF;
            default: f = neg ? 11'h400 : 11'h3FF;
        endcase
        return f;
    endfunction
`endif

    logic [1:0]         cnt_q, cnt_d;
    logic [ENTRY_W-1:0] head_q, head_d;
    logic [ENTRY_W-1:0] tail_q, tail_d;
    logic [ERR_W-1:0]   err_q, err_d;

    logic               in_fit;
    logic [10:0]        in_field;
    logic [ENTRY_W-1:0] in_entry;
    logic               in_ready;
    logic               out_valid;
    logic               acc;
    logic               pop;

    always_comb begin
        in_fit   = field_fits(IN_DATA, IN_SEL);
        in_field = trunc_field(IN_DATA[10:0], IN_SEL);
`ifdef SEXT_PACK_SAT_EN
        if (!in_fit) begin
            in_field = sat_field(IN_DATA[15], IN_SEL);
        end
`endif
        in_entry  = {in_field, IN_SEL, in_fit};

        // Ready depends on the count register only, so a pop never passes through when full.
        in_ready  = (cnt_q != FULL);
        out_valid = (cnt_q != 2'd0);
        acc       = IN_VALID & in_ready;
        pop       = out_valid & OUT_READY;

        cnt_d  = cnt_q;
        head_d = head_q;
        tail_d = tail_q;
        case (cnt_q)
            2'd0: begin
                if (acc) begin
                    head_d = in_entry;
                    cnt_d  = 2'd1;
                end
            end
            2'd1: begin
                case ({acc, pop})
                    2'b10: begin
                        tail_d = in_entry;
                        cnt_d  = 2'd2;
                    end
                    2'b01: cnt_d = 2'd0;
                    2'b11: head_d = in_entry;
                    default: ;
                endcase
            end
            default: begin
                if (pop) begin
                    head_d = tail_q;
                    cnt_d  = 2'd1;
                end
            end
        endcase

        err_d = err_q;
        if (acc && !in_fit && (err_q != ERR_MAX)) begin
            err_d = err_q + 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            cnt_q  <= 2'd0;
            head_q <= '0;
            tail_q <= '0;
            err_q  <= '0;
        end else begin
            cnt_q  <= cnt_d;
            head_q <= head_d;
            tail_q <= tail_d;
            err_q  <= err_d;
        end
    end

    assign IN_READY  = in_ready;
    assign OUT_VALID = out_valid;
    assign OUT_FIELD = head_q[13:3];
    assign OUT_SEL   = head_q[2:1];
    assign OUT_FIT   = head_q[0];
    assign ERR_COUNT = err_q;

endmodule

// File: tb/tb_sext_field_packer.sv
// Scoreboard bench for sext_field_packer: directed vectors, backpressure, streaming,
// counter saturation and mid-operation reset.
module tb_sext_field_packer;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        IN_VALID = 1'b0;
    logic        IN_READY;
    logic [15:0] IN_DATA = '0;
    logic [1:0]  IN_SEL = '0;
    logic        OUT_VALID;
    logic        OUT_READY = 1'b0;
    logic [10:0] OUT_FIELD;
    logic [1:0]  OUT_SEL;
    logic        OUT_FIT;
    logic [7:0]  ERR_COUNT;

    sext_field_packer #(.DEPTH(2), .ERR_W(8)) dut (
        .Clk(Clk), .Reset(Reset),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_DATA(IN_DATA), .IN_SEL(IN_SEL),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .OUT_FIELD(OUT_FIELD), .OUT_SEL(OUT_SEL), .OUT_FIT(OUT_FIT),
        .ERR_COUNT(ERR_COUNT)
    );

    always #5 Clk = ~Clk;

    int errors = 0;
    int checks = 0;
    int exp_err = 0;
    logic [13:0] sb[$];
    logic [13:0] cur_exp = '0;

    logic [15:0] v_data[12];
    logic [1:0]  v_sel[12];
    logic        v_fit[12];
    logic [10:0] v_trunc[12];
    logic [10:0] v_sat[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [10:0] exp_field(input int i);
`ifdef SEXT_PACK_SAT_EN
        return v_sat[i];
`else
        return v_trunc[i];
`endif
    endfunction

    task automatic set_vec(input int i, input logic [1:0] s, input logic [15:0] d,
                           input logic f, input logic [10:0] tr, input logic [10:0] st);
        v_sel[i] = s; v_data[i] = d; v_fit[i] = f; v_trunc[i] = tr; v_sat[i] = st;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input int i);
        IN_DATA  = v_data[i];
        IN_SEL   = v_sel[i];
        cur_exp  = {exp_field(i), v_sel[i], v_fit[i]};
        IN_VALID = 1'b1;
    endtask

    task automatic send(input int i);
        bit ok;
        ok = 0;
        drive(i);
        for (int n = 0; n < 50; n++) begin
            @(negedge Clk);
            if (IN_READY) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("send_timeout", 32'd0, 32'd1);
        tick();
        IN_VALID = 1'b0;
    endtask

    // Input monitor: an item presented while ready at the falling edge is accepted next rising edge.
    always @(negedge Clk) begin
        if (Reset && IN_VALID && IN_READY) begin
            sb.push_back(cur_exp);
            if (!cur_exp[0] && exp_err != 255) exp_err++;
        end
    end

    // Output monitor: every popped head is compared against the oldest expectation.
    always @(negedge Clk) begin
        if (Reset && OUT_VALID && OUT_READY) begin
            if (sb.size() == 0) begin
                chk("out_unexpected", {21'd0, OUT_FIELD}, 32'hFFFF_FFFF);
            end else begin
                logic [13:0] e;
                e = sb.pop_front();
                chk("out_entry", {18'd0, OUT_FIELD, OUT_SEL, OUT_FIT}, {18'd0, e});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //         idx sel  data      fit  trunc    sat
        set_vec(0,  2'd0, 16'hFFF0, 1'b1, 11'h010, 11'h010);
        set_vec(1,  2'd0, 16'h0010, 1'b0, 11'h010, 11'h00F);
        set_vec(2,  2'd3, 16'hFC00, 1'b1, 11'h400, 11'h400);
        set_vec(3,  2'd3, 16'h0400, 1'b0, 11'h400, 11'h3FF);
        set_vec(4,  2'd1, 16'hFFE0, 1'b1, 11'h020, 11'h020);
        set_vec(5,  2'd2, 16'h00FF, 1'b1, 11'h0FF, 11'h0FF);
        set_vec(6,  2'd2, 16'h0100, 1'b0, 11'h100, 11'h0FF);
        set_vec(7,  2'd1, 16'h8000, 1'b0, 11'h000, 11'h020);
        set_vec(8,  2'd0, 16'h000F, 1'b1, 11'h00F, 11'h00F);
        set_vec(9,  2'd2, 16'hFF00, 1'b1, 11'h100, 11'h100);
        set_vec(10, 2'd3, 16'h03FF, 1'b1, 11'h3FF, 11'h3FF);
        set_vec(11, 2'd0, 16'h7FFF, 1'b0, 11'h01F, 11'h00F);

        // Reset state
        repeat (2) tick();
        chk("rst_out_valid", OUT_VALID, 0);
        chk("rst_out_field", OUT_FIELD, 0);
        chk("rst_out_sel", OUT_SEL, 0);
        chk("rst_out_fit", OUT_FIT, 0);
        chk("rst_err", ERR_COUNT, 0);
        @(negedge Clk);
        Reset = 1'b1;
        tick();
        chk("rst_in_ready", IN_READY, 1);

        // Directed vectors, downstream always ready
        OUT_READY = 1'b1;
        send(0);
        chk("lat_out_valid", OUT_VALID, 1);
        chk("lat_out_field", OUT_FIELD, 11'h010);
        chk("lat_out_fit", OUT_FIT, 1);
        chk("lat_err", ERR_COUNT, 0);
        tick();
        send(1);
        chk("misfit_fit", OUT_FIT, 0);
        chk("misfit_field", OUT_FIELD, exp_field(1));
        chk("misfit_err", ERR_COUNT, 1);
        for (int i = 2; i < 12; i++) send(i);
        repeat (3) tick();
        chk("table_err", ERR_COUNT, 5);
        chk("table_drained", sb.size(), 0);

        // Backpressure: A and B fill the buffer, C waits upstream
        OUT_READY = 1'b0;
        drive(0);
        tick();
        drive(2);
        tick();
        chk("full_in_ready", IN_READY, 0);
        drive(4);
        for (int n = 0; n < 3; n++) begin
            tick();
            chk("stall_in_ready", IN_READY, 0);
            chk("stall_hold", {18'd0, OUT_FIELD, OUT_SEL, OUT_FIT}, {18'd0, 11'h010, 2'd0, 1'b1});
            if (n == 1) drive(9);
        end
        OUT_READY = 1'b1;
        tick();
        chk("pop_frees_slot", IN_READY, 1);
        chk("head_is_b", OUT_FIELD, 11'h400);
        tick();
        IN_VALID = 1'b0;
        chk("head_is_c", {21'd0, OUT_FIELD, OUT_SEL}, {21'd0, 11'h100, 2'd2});
        repeat (3) tick();
        chk("bp_drained", sb.size(), 0);

        // Streaming: one accept and one pop every cycle
        for (int k = 0; k < 12; k++) begin
            drive(k);
            tick();
            chk("stream_in_ready", IN_READY, 1);
            chk("stream_out_valid", OUT_VALID, 1);
            chk("stream_head", OUT_FIELD, exp_field(k));
        end
        IN_VALID = 1'b0;
        repeat (3) tick();
        chk("stream_err", ERR_COUNT, 10);

        // Counter saturation
        drive(1);
        repeat (300) @(posedge Clk);
        #1;
        IN_VALID = 1'b0;
        repeat (3) tick();
        chk("err_sat", ERR_COUNT, 255);
        chk("err_model", ERR_COUNT, exp_err);
        send(11);
        tick();
        chk("err_hold", ERR_COUNT, 255);

        // Reset with two items buffered
        repeat (3) tick();
        OUT_READY = 1'b0;
        drive(0);
        tick();
        drive(5);
        tick();
        IN_VALID = 1'b0;
        chk("pre_rst_full", IN_READY, 0);
        chk("pre_rst_valid", OUT_VALID, 1);
        #2;
        Reset = 1'b0;
        #1;
        chk("async_rst_valid", OUT_VALID, 0);
        chk("async_rst_err", ERR_COUNT, 0);
        chk("async_rst_field", OUT_FIELD, 0);
        chk("async_rst_fit", OUT_FIT, 0);
        sb.delete();
        exp_err = 0;
        @(negedge Clk);
        Reset = 1'b1;
        tick();
        chk("post_rst_ready", IN_READY, 1);
        chk("post_rst_valid", OUT_VALID, 0);
        OUT_READY = 1'b1;
        send(3);
        repeat (3) tick();
        chk("post_rst_err", ERR_COUNT, 1);
        chk("final_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sext_field_packer.md
Name: sext_field_packer

Overview:
- Inverse of the datapath sign-extension units. Takes a 16-bit two's-complement value plus a field selector and narrows it to an LC-3 immediate/offset field: imm5, offset6, PCoffset9 or PCoffset11.
- Reports whether the value fits the field; keeps a saturating count of misfits.
- Sits between the assembler/test-vector front end and the instruction-word builder, with valid/ready on both sides and a 2-entry output buffer.

Parameters:
- DEPTH, 2, output buffer entries. Fixed at 2; other values unsupported.
- ERR_W, 8, width of misfit counter.

Ports:
- Clk  in  1  clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- IN_VALID  in  1  upstream item valid.
- IN_READY  out  1  block can accept (buffer not full).
- IN_DATA  in  16  signed value to pack.
- IN_SEL  in  2  field select: 00 = imm5 (W=5), 01 = offset6 (W=6), 10 = PCoffset9 (W=9), 11 = PCoffset11 (W=11).
- OUT_VALID  out  1  head entry valid.
- OUT_READY  in  1  downstream accepts head.
- OUT_FIELD  out  11  packed field, right-justified, bits [10:W] forced 0.
- OUT_SEL  out  2  IN_SEL carried with the item.
- OUT_FIT  out  1  1 = IN_DATA[15:W-1] all equal, i.e. value representable in W bits.
- ERR_COUNT  out  ERR_W  saturating count of accepted items with FIT=0.

Behaviour:
- Reset (async assert, sync release):
  - Buffer count = 0, OUT_VALID = 0, OUT_FIELD/OUT_SEL/OUT_FIT = 0, ERR_COUNT = 0.
  - IN_READY = 1 once Reset is deasserted.
- Handshakes:
  - Accept when IN_VALID & IN_READY on a rising edge.
  - Pop when OUT_VALID & OUT_READY.
- IN_READY = (count != 2). It is combinational from the count register only, never from OUT_READY.
- Fit/pack is computed combinationally at the input. The entry stores {FIELD, SEL, FIT}.
  - FIELD = IN_DATA[W-1:0], zero-padded to 11 bits.
- Latency: accepted item appears on OUT_* the next cycle if the buffer was empty; FIFO order always preserved.
- Buffer cases:
  - Empty: accept → count 1.
  - One entry: accept only → count 2. Pop only → count 0. Accept + pop in the same cycle → count 1, new item becomes head.
  - Full: IN_READY = 0, input ignored even if IN_VALID = 1. Pop frees a slot, and IN_READY = 1 the following cycle (no same-cycle pass-through when full).
- OUT_* hold stable while OUT_VALID & !OUT_READY.
- ERR_COUNT:
  - Increments on each accept with FIT = 0.
  - Saturates at 2^ERR_W-1; no wrap.
  - Counts at acceptance, not at pop.
- Reset mid-operation: all buffered items are discarded; no partial output.
- IN_SEL changes while IN_VALID = 1 and IN_READY = 0 are legal; the value sampled at acceptance is used.

Optional Feature:
- SEXT_PACK_SAT_EN defined: when FIT = 0, FIELD saturates instead of truncating.
  - IN_DATA[15] = 0 → most-positive W-bit value (0x0F, 0x1F, 0xFF, 0x3FF).
  - IN_DATA[15] = 1 → most-negative value (0x10, 0x20, 0x100, 0x400).
  - OUT_FIT is still 0 and ERR_COUNT still increments.
- Undefined: FIELD is plain truncation IN_DATA[W-1:0].

Test Plan:
- imm5, IN_DATA = 0xFFF0 (-16), OUT_READY = 1 → next cycle OUT_VALID = 1, OUT_FIELD = 0x010, OUT_FIT = 1, ERR_COUNT = 0.
- imm5, IN_DATA = 0x0010 (+16) → OUT_FIT = 0, ERR_COUNT = 1. OUT_FIELD = 0x010 without SEXT_PACK_SAT_EN, 0x00F with it.
- PCoffset11, 0xFC00 → FIELD = 0x400, FIT = 1. PCoffset11, 0x0400 → FIT = 0. offset6, 0xFFE0 → FIELD = 0x20, FIT = 1.
- OUT_READY = 0, push A, B, C back-to-back:
  - IN_READY drops after B; C is held upstream.
  - Raise OUT_READY → outputs A, B, C in order; C accepted the cycle after the first pop.
- Steady stream with OUT_READY = 1 and count = 1 → simultaneous accept/pop every cycle, count stays 1, throughput 1 item/cycle.
- 300 misfit items → ERR_COUNT = 255, holds. Assert Reset with 2 items buffered → OUT_VALID = 0, ERR_COUNT = 0 immediately; IN_READY = 1 after release.
